// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - registered ALU plus iterative shift-add multiplier and restoring divider behind valid/ready ports
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             overflow,
    output logic             busy
);
    localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011, OP_XOR  = 5'b00100, OP_SLT   = 5'b00101;
    localparam logic [4:0] OP_SLTU = 5'b00110, OP_PASS = 5'b00111, OP_SRL   = 5'b01000;
    localparam logic [4:0] OP_SRA  = 5'b01001, OP_SLL  = 5'b01010, OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULHU = 5'b10011, OP_DIV = 5'b10100, OP_DIVU  = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b10110, OP_REMU = 5'b10111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   opnd;
    logic [4:0]         op_r;
    logic               neg_q, neg_r;

    logic accept, is_mul, is_div, is_sdiv, div_zero, start_calc, last_step, load_res;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid  = (state == DONE);
    assign busy       = (state == CALC);
    assign accept     = in_valid && in_ready;
    assign is_mul     = (op == OP_MUL) || (op == OP_MULHU);
    assign is_div     = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    assign is_sdiv    = (op == OP_DIV) || (op == OP_REM);
    assign div_zero   = is_div && (src_b == '0);
    assign start_calc = (is_mul || is_div) && !div_zero;
    assign last_step  = (state == CALC) && (cnt == '0);
    assign load_res   = (accept && !start_calc) || last_step;

    // Divider iterates on magnitudes; signs are reapplied at the final step.
    assign a_neg = is_sdiv && src_a[WIDTH-1];
    assign b_neg = is_sdiv && src_b[WIDTH-1];
    assign a_mag = a_neg ? ({WIDTH{1'b0}} - src_a) : src_a;
    assign b_mag = b_neg ? ({WIDTH{1'b0}} - src_b) : src_b;

    logic [WIDTH:0]   add_full, sub_full;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_known;

    assign add_full = {1'b0, src_a} + {1'b0, src_b};
    assign sub_full = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt    = src_b[SHW-1:0];

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_known = 1'b1;
        case (op)
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_full[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_full[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            OP_PASS: alu_res = src_b;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
            OP_SLL:  alu_res = src_a << shamt;
            default: alu_known = 1'b0;
        endcase
    end

    // acc holds {high, low} product for multiply and {remainder, quotient} for divide.
    logic [WIDTH:0] mul_sum, shifted, trial;

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = shifted - {1'b0, opnd};
        if (op_r == OP_MUL || op_r == OP_MULHU)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (!trial[WIDTH])
            acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    logic [WIDTH-1:0] nx_res;
    logic             nx_c, nx_v, nx_flag;

    always_comb begin
        nx_res  = alu_res;
        nx_c    = alu_c;
        nx_v    = alu_v;
        nx_flag = alu_known;
        if (state == CALC) begin
            nx_c    = 1'b0;
            nx_v    = 1'b0;
            nx_flag = 1'b1;
            case (op_r)
                OP_MUL:          nx_res = acc_step[WIDTH-1:0];
                OP_MULHU:        nx_res = acc_step[2*WIDTH-1:WIDTH];
                OP_DIV, OP_DIVU: nx_res = neg_q ? ({WIDTH{1'b0}} - acc_step[WIDTH-1:0]) : acc_step[WIDTH-1:0];
                default:         nx_res = neg_r ? ({WIDTH{1'b0}} - acc_step[2*WIDTH-1:WIDTH])
                                                : acc_step[2*WIDTH-1:WIDTH];
            endcase
        end else if (div_zero) begin
            nx_c    = 1'b0;
            nx_v    = 1'b0;
            nx_flag = 1'b1;
            nx_res  = (op == OP_REM || op == OP_REMU) ? src_a : {WIDTH{1'b1}};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = start_calc ? CALC : DONE;
            CALC: if (cnt == '0) state_nx = DONE;
            DONE: if (out_ready) state_nx = !in_valid ? IDLE : (start_calc ? CALC : DONE);
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_r     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            sign     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept && start_calc) begin
                cnt   <= SHW'(WIDTH - 1);
                op_r  <= op;
                opnd  <= is_mul ? src_a : b_mag;
                acc   <= {{WIDTH{1'b0}}, (is_mul ? src_b : a_mag)};
                neg_q <= is_sdiv && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_r <= a_neg;
            end else if (state == CALC) begin
                acc <= acc_step;
                if (cnt != '0) cnt <= cnt - SHW'(1);
            end
            if (load_res) begin
                result   <= nx_res;
                zero     <= nx_flag && (nx_res == '0);
                sign     <= nx_flag && nx_res[WIDTH-1];
                carry    <= nx_c;
                overflow <= nx_v;
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - self-checking bench for alu_mdu: vector table, random ops vs reference model, handshake and reset sequences
module tb_alu_mdu;
    localparam int W = 32;
    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, AND_ = 5'b00010, OR_ = 5'b00011;
    localparam logic [4:0] XOR_ = 5'b00100, SLT = 5'b00101, SLTU = 5'b00110, PASS = 5'b00111;
    localparam logic [4:0] SRL = 5'b01000, SRA = 5'b01001, SLL = 5'b01010, MUL = 5'b10000;
    localparam logic [4:0] MULHU = 5'b10011, DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flags;
        int           lat;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, zero, carry, sign, overflow, busy;
    logic [4:0]   op = '0;
    logic [W-1:0] src_a = '0, src_b = '0, result;

    int n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .sign(sign), .overflow(overflow), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] r, input logic [3:0] f, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.res = r; v.flags = f; v.lat = lat;
        return v;
    endfunction

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic vec_t model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        longint sa, sb, t;
        logic [63:0] prod;
        logic [4:0] sh;
        logic [W-1:0] r;
        logic c, ov, known;
        sa = $signed(a);
        sb = $signed(b);
        prod = {32'b0, a} * {32'b0, b};
        sh = b[4:0];
        c = 1'b0; ov = 1'b0; known = 1'b1; r = '0;
        case (o)
            ADD:   begin r = a + b; c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
                         t = sa + sb; ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            SUB:   begin r = a - b; c = (a >= b);
                         t = sa - sb; ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            AND_:  r = a & b;
            OR_:   r = a | b;
            XOR_:  r = a ^ b;
            SLT:   r = (sa < sb) ? 32'd1 : 32'd0;
            SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            PASS:  r = b;
            SRL:   r = a >> sh;
            SRA:   r = $unsigned($signed(a) >>> sh);
            SLL:   r = a << sh;
            MUL:   r = prod[31:0];
            MULHU: r = prod[63:32];
            DIV:   r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            DIVU:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:   r = (b == 0) ? a : 32'(sa % sb);
            REMU:  r = (b == 0) ? a : a % b;
            default: known = 1'b0;
        endcase
        v.op = o; v.a = a; v.b = b; v.res = r;
        v.flags = {known && (r == 0), c, known && r[31], ov};
        v.lat = ((o == MUL || o == MULHU) || ((o == DIV || o == DIVU || o == REM || o == REMU) && b != 0)) ? W + 1 : 1;
        return v;
    endfunction

    task automatic do_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [3:0] f, output int lat, output int bcnt);
        int n;
        n = 0;
        @(negedge clk);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("in_ready_wait", n < 100, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 5'($urandom); src_a = $urandom; src_b = $urandom;
        lat = 1; bcnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        f = {zero, carry, sign, overflow};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("taken_clears_valid", out_valid, 0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t e;
        logic [4:0] op_pool[19];
        logic [W-1:0] r;
        logic [3:0] f;
        int lat, bcnt, stale;

        op_pool = '{ADD, SUB, AND_, OR_, XOR_, SLT, SLTU, PASS, SRL, SRA, SLL,
                    MUL, MULHU, DIV, DIVU, REM, REMU, 5'b01011, 5'b11111};

        tbl.push_back(mk(ADD,   32'hFFFF_FFFF, 32'h1,          32'h0,         4'b1100, 1));
        tbl.push_back(mk(SUB,   32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 4'b0101, 1));
        tbl.push_back(mk(SUB,   32'd5,         32'd7,          32'hFFFF_FFFE, 4'b0010, 1));
        tbl.push_back(mk(SRA,   32'h8000_0000, 32'h24,         32'hF800_0000, 4'b0010, 1));
        tbl.push_back(mk(SLL,   32'h1,         32'h21,         32'h2,         4'b0000, 1));
        tbl.push_back(mk(SLT,   32'hFFFF_FFFF, 32'h1,          32'h1,         4'b0000, 1));
        tbl.push_back(mk(SLTU,  32'hFFFF_FFFF, 32'h1,          32'h0,         4'b1000, 1));
        tbl.push_back(mk(PASS,  32'h0,         32'hABCD,       32'hABCD,      4'b0000, 1));
        tbl.push_back(mk(5'b11111, 32'h1234,   32'h5678,       32'h0,         4'b0000, 1));
        tbl.push_back(mk(MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h1,         4'b0000, 33));
        tbl.push_back(mk(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 4'b0010, 33));
        tbl.push_back(mk(DIV,   32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD, 4'b0010, 33));
        tbl.push_back(mk(REM,   32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 4'b0010, 33));
        tbl.push_back(mk(DIVU,  32'd100,       32'd0,          32'hFFFF_FFFF, 4'b0010, 1));
        tbl.push_back(mk(REMU,  32'd5,         32'd0,          32'd5,         4'b0000, 1));
        tbl.push_back(mk(DIVU,  32'd100,       32'd7,          32'd14,        4'b0000, 33));
        tbl.push_back(mk(DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 4'b0010, 33));
        tbl.push_back(mk(REM,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         4'b1000, 33));

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_flags", {zero, carry, sign, overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, f, lat, bcnt);
            check($sformatf("vec%0d_result", i), r, tbl[i].res);
            check($sformatf("vec%0d_flags", i), f, tbl[i].flags);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, (tbl[i].lat == 1) ? 0 : W);
        end

        for (int i = 0; i < 60; i++) begin
            logic [4:0] o;
            logic [W-1:0] a, b;
            o = op_pool[$urandom_range(0, 18)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = $urandom_range(1, 9);
                2: a = 32'h8000_0000;
                3: b = '1;
                default: ;
            endcase
            e = model(o, a, b);
            do_op(o, a, b, r, f, lat, bcnt);
            check($sformatf("rnd%0d_op%0h_result", i, o), r, e.res);
            check($sformatf("rnd%0d_op%0h_flags", i, o), f, e.flags);
            check($sformatf("rnd%0d_op%0h_latency", i, o), lat, e.lat);
        end

        // Stall the consumer on an AND result, then take it while handing in an OR.
        @(negedge clk);
        op = AND_; src_a = 32'hF0F0_1234; src_b = 32'h0FF0_FF00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_first_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_result", k), result, 32'h00F0_1200);
            check($sformatf("hold%0d_flags", k), {zero, carry, sign, overflow}, 4'b0000);
            check($sformatf("hold%0d_in_ready", k), in_ready, 0);
            check($sformatf("hold%0d_out_valid", k), out_valid, 1);
        end
        op = OR_; src_a = 32'h8000_0001; src_b = 32'h0000_0100; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_out_valid", out_valid, 1);
        check("b2b_result", result, 32'h8000_0101);
        check("b2b_sign", sign, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_taken", out_valid, 0);

        // Reset mid-DIVU: clears immediately and leaves no stale result behind.
        @(negedge clk);
        op = DIVU; src_a = 32'd1000; src_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("divu_busy", busy, 1);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        check("midrst_flags", {zero, carry, sign, overflow}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) stale++;
        end
        check("midrst_no_stale", stale, 0);
        do_op(ADD, 32'd2, 32'd3, r, f, lat, bcnt);
        check("post_rst_add", r, 32'd5);
        check("post_rst_latency", lat, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked successor to the single-cycle datapath ALU: a registered ALU plus an iterative multiply/divide unit behind one valid/ready operand port and one valid/ready result port. It sits in the execute stage; the control unit presents an opcode and two operands and stalls until the result is accepted. Single-cycle ops return after 1 cycle; MUL/DIV-class ops take WIDTH+1 cycles.

## Interface
- WIDTH, 32, operand/result width; must be a power of two and at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  unit can accept; transfer occurs when in_valid && in_ready.
- op  in  5  operation code, see Operation.
- src_a  in  WIDTH  operand A / dividend / multiplicand.
- src_b  in  WIDTH  operand B / divisor / multiplier / shift amount.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready.
- result  out  WIDTH  registered result.
- zero, carry, sign, overflow  out  1 each  registered flags.
- busy  out  1  high in CALC state.

## Operation
- Op codes: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00101 (signed), SLTU 00110, PASS 00111 (result = src_b), SRL 01000, SRA 01001, SLL 01010, MUL 10000 (low WIDTH bits), MULHU 10011 (high WIDTH bits, unsigned), DIV 10100, DIVU 10101, REM 10110, REMU 10111. Any other code: result 0, all flags 0, single-cycle path.
- Shifts use src_b[SHW-1:0] only; SRA replicates src_a[WIDTH-1].
- SLT/SLTU produce 0 or 1 in bit 0, upper bits 0.
- Flags: zero = (result == 0); sign = result[WIDTH-1]; carry = carry out of src_a + src_b (ADD) or of src_a + ~src_b + 1 (SUB, 1 = no borrow), else 0; overflow = signed overflow for ADD/SUB, else 0.
- Multiply: shift-add, one multiplier bit per CALC cycle, 2*WIDTH-bit accumulator.
- Divide: restoring, one quotient bit per CALC cycle on magnitudes; signed ops negate quotient if operand signs differ, remainder takes dividend sign.
- Divisor zero (detected at accept): skip CALC; DIV/DIVU → all ones, REM/REMU → src_a.
- Signed overflow DIV: src_a = most negative, src_b = all ones → quotient = src_a, REM → 0; computed by the normal iterative path.
- Operands are latched at accept; src_a/src_b/op changes afterwards have no effect.

## Timing
- FSM states IDLE, CALC, DONE. Reset → IDLE.
- IDLE: in_ready = 1. On accept: single-cycle op or divisor zero → DONE with result registered; MUL/DIV class → CALC, counter = WIDTH-1.
- CALC: in_ready = 0, busy = 1; counter decrements each cycle; at counter 0, sign fix-up applied and result registered → DONE. Total CALC cycles = WIDTH.
- DONE: out_valid = 1; result/flags held stable until out_ready. in_ready = out_ready (back-to-back: a new op accepted in the same cycle the result is taken; next state per new op). out_ready without in_valid → IDLE.
- Latency accept→out_valid: 1 cycle single-cycle ops; WIDTH+1 cycles MUL/DIV class.
- Reset values (also on rst_n asserted mid-CALC or mid-DONE, immediately): state IDLE, out_valid 0, busy 0, result 0, all flags 0, counter 0; in-flight op is discarded.
- in_ready is combinational from state and out_ready only; out_valid, result and flags come straight from registers.

## Test plan
- Reset then ADD 0xFFFFFFFF + 0x00000001 → out_valid 1 cycle after accept, result 0, zero 1, carry 1, overflow 0.
- SUB 0x80000000 - 0x00000001 → result 0x7FFFFFFF, overflow 1, carry 1, sign 0; SRA 0x80000000 by src_b 0x00000024 → 0xF8000000 (uses 4).
- MUL 0xFFFFFFFF × 0xFFFFFFFF → result 0x00000001 at accept+33 cycles, busy high 32 cycles; MULHU same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/0 → 0xFFFFFFFF after 1 cycle; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- Hold out_ready 0 for 5 cycles after an AND result → result/flags stable, in_ready 0; then out_ready 1 with in_valid 1 (OR) → OR accepted same cycle, its result valid next cycle.
- Assert rst_n low 10 cycles into a DIVU → out_valid, busy, result cleared asynchronously; after release, in_ready 1 and no stale result emitted.
